// File: rtl/axi_rd_pkg.sv
// Shared types and constants for the AXI read-data return path.
package axi_rd_pkg;

    // Slave count: S0 (instruction memory), S1 (data memory), default slave.
    localparam int NUM_SLV = 3;

    // Master tags carried in RID[7:4] of every read-data beat.
    localparam logic [3:0] TAG_M0 = 4'b0001;
    localparam logic [3:0] TAG_M1 = 4'b0010;

    // Per-master routing state: free to arbitrate, or locked to one burst.
    typedef enum logic {
        IDLE,
        LOCK
    } rd_state_e;

    // Slave index, also the round-robin order.
    typedef enum logic [1:0] {
        S_S0 = 2'd0,
        S_S1 = 2'd1,
        S_SD = 2'd2
    } slv_idx_e;

    // Next slave in round-robin order, wrapping after the default slave.
    function automatic slv_idx_e next_slv(input slv_idx_e s);
        case (s)
            S_S0:    return S_S1;
            S_S1:    return S_SD;
            default: return S_S0;
        endcase
    endfunction

endpackage

// File: rtl/rr_arb3.sv
// Three-request round-robin arbiter: grants the first requester at or after ptr.
module rr_arb3
    import axi_rd_pkg::*;
(
    input  logic [2:0] req,
    input  slv_idx_e   ptr,
    output logic       gnt_vld,
    output slv_idx_e   gnt_idx
);

    slv_idx_e cand;

    // Walk the three slots starting at ptr and keep the first requester found.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
        gnt_vld = 1'b0;
        gnt_idx = ptr;
        cand    = ptr;
        for (int i = 0; i < 3; i++) begin
            if (!gnt_vld && req[cand]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand;
            end
            cand = next_slv(cand);
        end
    end

endmodule

// File: rtl/read_data_router.sv
// R-channel return path: steers slave read-data bursts to M0/M1 by RID tag,
// locking each master to one slave for the duration of a burst.
module read_data_router
    import axi_rd_pkg::*;
#(
    parameter int         NUM_S  = NUM_SLV,
    parameter logic [3:0] TAG_M0 = axi_rd_pkg::TAG_M0,
    parameter logic [3:0] TAG_M1 = axi_rd_pkg::TAG_M1
) (
    input  logic        clk,
    input  logic        rst,

    input  logic [7:0]  RID_S0,
    input  logic [31:0] RDATA_S0,
    input  logic [1:0]  RRESP_S0,
    input  logic        RLAST_S0,
    input  logic        RVALID_S0,
    output logic        RREADY_S0,

    input  logic [7:0]  RID_S1,
    input  logic [31:0] RDATA_S1,
    input  logic [1:0]  RRESP_S1,
    input  logic        RLAST_S1,
    input  logic        RVALID_S1,
    output logic        RREADY_S1,

    input  logic [7:0]  RID_SDEFAULT,
    input  logic [31:0] RDATA_SDEFAULT,
    input  logic [1:0]  RRESP_SDEFAULT,
    input  logic        RLAST_SDEFAULT,
    input  logic        RVALID_SDEFAULT,
    output logic        RREADY_SDEFAULT,

    output logic [3:0]  RID_M0,
    output logic [31:0] RDATA_M0,
    output logic [1:0]  RRESP_M0,
    output logic        RLAST_M0,
    output logic        RVALID_M0,
    input  logic        RREADY_M0,

    output logic [3:0]  RID_M1,
    output logic [31:0] RDATA_M1,
    output logic [1:0]  RRESP_M1,
    output logic        RLAST_M1,
    output logic        RVALID_M1,
    input  logic        RREADY_M1
);

    // Slave-side bundle, indexed by slv_idx_e.
    logic [7:0]       s_id    [NUM_S];
    logic [31:0]      s_data  [NUM_S];
    logic [1:0]       s_resp  [NUM_S];
    logic [NUM_S-1:0] s_last;
    logic [NUM_S-1:0] s_valid;
    logic [NUM_S-1:0] s_ready;

    assign s_id[0]   = RID_S0;
    assign s_id[1]   = RID_S1;
    assign s_id[2]   = RID_SDEFAULT;
    assign s_data[0] = RDATA_S0;
    assign s_data[1] = RDATA_S1;
    assign s_data[2] = RDATA_SDEFAULT;
    assign s_resp[0] = RRESP_S0;
    assign s_resp[1] = RRESP_S1;
    assign s_resp[2] = RRESP_SDEFAULT;
    assign s_last    = {RLAST_SDEFAULT, RLAST_S1, RLAST_S0};
    assign s_valid   = {RVALID_SDEFAULT, RVALID_S1, RVALID_S0};

    assign RREADY_S0       = s_ready[0];
    assign RREADY_S1       = s_ready[1];
    assign RREADY_SDEFAULT = s_ready[2];

    // Master-side bundle, index 0 = M0, 1 = M1.
    logic [1:0]             m_ready;
    logic [1:0]             m_valid;
    logic [1:0]             m_last;
    logic [1:0][3:0]        m_id;
    logic [1:0][31:0]       m_data;
    logic [1:0][1:0]        m_resp;
    logic [1:0][NUM_S-1:0]  m_route;   // one-hot slave currently connected to each master

    assign m_ready   = {RREADY_M1, RREADY_M0};
    assign RVALID_M0 = m_valid[0];
    assign RLAST_M0  = m_last[0];
    assign RID_M0    = m_id[0];
    assign RDATA_M0  = m_data[0];
    assign RRESP_M0  = m_resp[0];
    assign RVALID_M1 = m_valid[1];
    assign RLAST_M1  = m_last[1];
    assign RID_M1    = m_id[1];
    assign RDATA_M1  = m_data[1];
    assign RRESP_M1  = m_resp[1];

    logic [NUM_S-1:0] to_m0;
    logic [NUM_S-1:0] to_m1;
    logic [NUM_S-1:0] sink;

    // Decode each valid beat's tag into a request for M0, M1, or a discard.
    always_comb begin
        to_m0 = '0;
        to_m1 = '0;
        sink  = '0;
        for (int s = 0; s < NUM_S; s++) begin
            to_m0[s] = s_valid[s] && (s_id[s][7:4] == TAG_M0);
            to_m1[s] = s_valid[s] && (s_id[s][7:4] == TAG_M1);
            sink[s]  = s_valid[s] && !(s_id[s][7:4] == TAG_M0) && !(s_id[s][7:4] == TAG_M1);
        end
    end

    for (genvar m = 0; m < 2; m++) begin : g_mst
        logic [NUM_S-1:0] req;
        rd_state_e        state_q;
        slv_idx_e         owner_q;
        slv_idx_e         ptr_q;
        logic             gnt_vld;
        slv_idx_e         gnt_idx;
        logic             active;
        slv_idx_e         sel;
        logic             hs_last;

        assign req = (m == 0) ? to_m0 : to_m1;

        rr_arb3 u_arb (
            .req     (req),
            .ptr     (ptr_q),
            .gnt_vld (gnt_vld),
            .gnt_idx (gnt_idx)
        );

        // Select the connected slave: the owner while locked, else this cycle's winner.
        always_comb begin
            active = 1'b0;
            sel    = owner_q;
            if (!rst) begin
                if (state_q == LOCK) begin
                    active = 1'b1;
                    sel    = owner_q;
                end else if (gnt_vld) begin
                    active = 1'b1;
                    sel    = gnt_idx;
                end
            end
        end

        assign hs_last    = active && m_ready[m] && s_valid[sel] && s_last[sel];
        assign m_valid[m] = active && s_valid[sel];
        assign m_last[m]  = active && s_last[sel];
        assign m_id[m]    = active ? s_id[sel][3:0] : '0;
        assign m_data[m]  = active ? s_data[sel]    : '0;
        assign m_resp[m]  = active ? s_resp[sel]    : '0;
        assign m_route[m] = active ? (NUM_S'(1) << sel) : '0;

        // Burst lock FSM: a grant that does not finish with an RLAST handshake locks the master.
        always_ff @(posedge clk) begin
            if (rst) begin
                // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
                state_q <= IDLE;
                owner_q <= S_S0;
                ptr_q   <= S_S0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (gnt_vld) begin
                            if (hs_last) begin
                                ptr_q <= next_slv(gnt_idx);
                            end else begin
                                state_q <= LOCK;
                                owner_q <= gnt_idx;
                            end
                        end
                    end
                    LOCK: begin
                        if (hs_last) begin
                            state_q <= IDLE;
                            ptr_q   <= next_slv(owner_q);
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    // Slave ready: the routed master's ready, or an unconditional sink for unknown tags.
    always_comb begin
        s_ready = '0;
        for (int s = 0; s < NUM_S; s++) begin
            s_ready[s] = !rst && (sink[s]
                                  || (m_route[0][s] && m_ready[0])
                                  || (m_route[1][s] && m_ready[1]));
        end
    end

endmodule

// File: tb/tb_read_data_router.sv
// Self-checking bench for read_data_router: directed scenarios with literal
// expectations, then randomized bursts checked every cycle against a model.
module tb_read_data_router;

    localparam logic [3:0] TAG0 = 4'h1;
    localparam logic [3:0] TAG1 = 4'h2;

    logic        clk = 1'b0;
    logic        rst;

    logic [7:0]  rid    [3];
    logic [31:0] rdata  [3];
    logic [1:0]  rresp  [3];
    logic        rlast  [3];
    logic        rvalid [3];
    logic        rready_s [3];

    logic [3:0]  rid_m    [2];
    logic [31:0] rdata_m  [2];
    logic [1:0]  rresp_m  [2];
    logic        rlast_m  [2];
    logic        rvalid_m [2];
    logic        rready_m [2];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    read_data_router dut (
        .clk             (clk),
        .rst             (rst),
        .RID_S0          (rid[0]),
        .RDATA_S0        (rdata[0]),
        .RRESP_S0        (rresp[0]),
        .RLAST_S0        (rlast[0]),
        .RVALID_S0       (rvalid[0]),
        .RREADY_S0       (rready_s[0]),
        .RID_S1          (rid[1]),
        .RDATA_S1        (rdata[1]),
        .RRESP_S1        (rresp[1]),
        .RLAST_S1        (rlast[1]),
        .RVALID_S1       (rvalid[1]),
        .RREADY_S1       (rready_s[1]),
        .RID_SDEFAULT    (rid[2]),
        .RDATA_SDEFAULT  (rdata[2]),
        .RRESP_SDEFAULT  (rresp[2]),
        .RLAST_SDEFAULT  (rlast[2]),
        .RVALID_SDEFAULT (rvalid[2]),
        .RREADY_SDEFAULT (rready_s[2]),
        .RID_M0          (rid_m[0]),
        .RDATA_M0        (rdata_m[0]),
        .RRESP_M0        (rresp_m[0]),
        .RLAST_M0        (rlast_m[0]),
        .RVALID_M0       (rvalid_m[0]),
        .RREADY_M0       (rready_m[0]),
        .RID_M1          (rid_m[1]),
        .RDATA_M1        (rdata_m[1]),
        .RRESP_M1        (rresp_m[1]),
        .RLAST_M1        (rlast_m[1]),
        .RVALID_M1       (rvalid_m[1]),
        .RREADY_M1       (rready_m[1])
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------------
    // Reference model: each master remembers which slave (if any) holds its
    // current burst and which slave has first claim on the next one.
    // ---------------------------------------------------------------------
    int          burst_of [2];   // slave holding the master, -1 when free
    int          first_in [2];   // slave with priority for the next burst
    int          route    [2];
    int          dest     [3];   // -2 no beat, -1 unknown tag, else master
    logic [2:0]  exp_rdy;
    logic [2:0]  act_rdy;
    logic [39:0] exp_m;
    logic [39:0] act_m;
    logic [2:0]  hs;             // beats accepted at the coming edge
    bit          chk_en = 1'b0;

    initial begin
        burst_of = '{-1, -1};
        first_in = '{0, 0};
        hs       = '0;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                for (int s = 0; s < 3; s++) begin
                    if (!rvalid[s])                dest[s] = -2;
                    else if (rid[s][7:4] == TAG0)  dest[s] = 0;
                    else if (rid[s][7:4] == TAG1)  dest[s] = 1;
                    else                           dest[s] = -1;
                end
                for (int m = 0; m < 2; m++) begin
                    route[m] = burst_of[m];
                    for (int d = 0; d < 3; d++)
                        if (route[m] < 0 && dest[(first_in[m] + d) % 3] == m)
                            route[m] = (first_in[m] + d) % 3;
                    if (rst) route[m] = -1;
                end
                for (int m = 0; m < 2; m++) begin
                    exp_m = '0;
                    if (route[m] >= 0)
                        exp_m = {rvalid[route[m]], rid[route[m]][3:0], rdata[route[m]],
                                 rresp[route[m]], rlast[route[m]]};
                    act_m = {rvalid_m[m], rid_m[m], rdata_m[m], rresp_m[m], rlast_m[m]};
                    check($sformatf("m%0d_outputs", m), act_m, exp_m);
                end
                for (int s = 0; s < 3; s++) begin
                    exp_rdy[s] = !rst && ((dest[s] == -1)
                                          || (route[0] == s && rready_m[0])
                                          || (route[1] == s && rready_m[1]));
                    act_rdy[s] = rready_s[s];
                    hs[s]      = rvalid[s] && exp_rdy[s];
                end
                check("slave_ready", act_rdy, exp_rdy);
                for (int m = 0; m < 2; m++) begin
                    if (rst) begin
                        burst_of[m] = -1;
                        first_in[m] = 0;
                    end else if (route[m] >= 0) begin
                        if (rvalid[route[m]] && rready_m[m] && rlast[route[m]]) begin
                            burst_of[m] = -1;
                            first_in[m] = (route[m] + 1) % 3;
                        end else begin
                            burst_of[m] = route[m];
                        end
                    end
                end
            end
        end
    end

    // ---------------------------------------------------------------------
    // Stimulus helpers: inputs change 1 time unit after posedge, literal
    // checks happen 1 time unit after negedge.
    // ---------------------------------------------------------------------
    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic clr();
        for (int s = 0; s < 3; s++) begin
            rvalid[s] = 1'b0;
            rlast[s]  = 1'b0;
            rid[s]    = '0;
            rdata[s]  = '0;
            rresp[s]  = '0;
        end
        rready_m[0] = 1'b0;
        rready_m[1] = 1'b0;
    endtask

    task automatic drive(input int s, input logic [7:0] id, input logic [31:0] d, input logic l);
        rvalid[s] = 1'b1;
        rid[s]    = id;
        rdata[s]  = d;
        rresp[s]  = 2'b00;
        rlast[s]  = l;
    endtask

    task automatic do_reset();
        next();
        clr();
        rst = 1'b1;
        next();
        rst = 1'b0;
    endtask

    int left [3];
    int pick;

    initial begin
        rst = 1'b1;
        clr();
        chk_en = 1'b1;

        // Reset: outputs forced to 0 even with a live request.
        drive(0, 8'h10, 32'h1234_5678, 1'b1);
        rready_m[0] = 1'b1;
        settle();
        check("reset_rvalid_m0", rvalid_m[0], 0);
        check("reset_rdata_m0", rdata_m[0], 0);
        check("reset_rready_s0", rready_s[0], 0);

        // Single beat S1 -> M0, same-cycle pass-through.
        do_reset();
        drive(1, 8'h12, 32'hDEADBEEF, 1'b1);
        rready_m[0] = 1'b1;
        settle();
        check("single_rvalid_m0", rvalid_m[0], 1);
        check("single_rid_m0", rid_m[0], 4'h2);
        check("single_rdata_m0", rdata_m[0], 32'hDEADBEEF);
        check("single_rready_s1", rready_s[1], 1);
        next();
        rvalid[1] = 1'b0;
        drive(0, 8'h19, 32'h0000_0009, 1'b1);
        settle();
        check("single_no_lock_rready_s0", rready_s[0], 1);
        check("single_no_lock_rid_m0", rid_m[0], 4'h9);

        // Lock: S0 4-beat burst to M1, S1 waits from beat 2.
        do_reset();
        rready_m[1] = 1'b1;
        for (int b = 1; b <= 4; b++) begin
            drive(0, 8'h23, 32'h1000_0000 + 32'(b), b == 4);
            if (b >= 2) drive(1, 8'h25, 32'h2222_2222, 1'b1);
            settle();
            check("lock_rready_s0", rready_s[0], 1);
            check("lock_rready_s1", rready_s[1], 0);
            check("lock_rdata_m1", rdata_m[1], 32'h1000_0000 + 32'(b));
            next();
        end
        rvalid[0] = 1'b0;
        settle();
        check("lock_s1_served_rready", rready_s[1], 1);
        check("lock_s1_served_rid", rid_m[1], 4'h5);
        check("lock_s1_served_rdata", rdata_m[1], 32'h2222_2222);

        // Back-pressure: S0 held 3 cycles, competing S1 never granted.
        do_reset();
        drive(0, 8'h15, 32'hA5A5_A5A5, 1'b1);
        for (int i = 0; i < 3; i++) begin
            if (i >= 1) drive(1, 8'h16, 32'h0BAD_0BAD, 1'b1);
            settle();
            check("bp_rvalid_m0", rvalid_m[0], 1);
            check("bp_rdata_m0", rdata_m[0], 32'hA5A5_A5A5);
            check("bp_rready_s0", rready_s[0], 0);
            check("bp_rready_s1", rready_s[1], 0);
            next();
        end
        rready_m[0] = 1'b1;
        settle();
        check("bp_release_s0", rready_s[0], 1);
        check("bp_release_s1", rready_s[1], 0);
        next();
        rvalid[0] = 1'b0;
        settle();
        check("bp_then_s1", rready_s[1], 1);
        check("bp_then_s1_rid", rid_m[0], 4'h6);

        // Round-robin: three persistent single-beat requesters to M0.
        do_reset();
        drive(0, 8'h10, 32'hA0, 1'b1);
        drive(1, 8'h11, 32'hA1, 1'b1);
        drive(2, 8'h12, 32'hA2, 1'b1);
        rready_m[0] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            settle();
            check("rr_rid_m0", rid_m[0], 4'(i % 3));
            check("rr_ready_onehot", {rready_s[2], rready_s[1], rready_s[0]}, 3'b001 << (i % 3));
            next();
        end

        // Concurrency and unknown tag.
        do_reset();
        drive(0, 8'h13, 32'h0000_00A0, 1'b1);
        drive(1, 8'h24, 32'h0000_00B1, 1'b1);
        drive(2, 8'h70, 32'hFFFF_FFFF, 1'b1);
        rready_m[0] = 1'b1;
        rready_m[1] = 1'b1;
        settle();
        check("conc_m0", {rvalid_m[0], rid_m[0]}, {1'b1, 4'h3});
        check("conc_m1", {rvalid_m[1], rid_m[1]}, {1'b1, 4'h4});
        check("conc_readies", {rready_s[2], rready_s[1], rready_s[0]}, 3'b111);
        next();
        rvalid[0] = 1'b0;
        rvalid[1] = 1'b0;
        settle();
        check("badtag_sink", rready_s[2], 1);
        check("badtag_no_valid", {rvalid_m[1], rvalid_m[0]}, 2'b00);

        // Reset during beat 2 of a locked burst.
        do_reset();
        drive(0, 8'h15, 32'h0000_0001, 1'b0);
        rready_m[0] = 1'b1;
        settle();
        next();
        drive(0, 8'h15, 32'h0000_0002, 1'b0);
        rst = 1'b1;
        settle();
        check("midrst_outputs", {rvalid_m[0], rdata_m[0], rready_s[0]}, 0);
        next();
        rst = 1'b0;
        rvalid[0] = 1'b0;
        drive(1, 8'h17, 32'h0000_0003, 1'b1);
        settle();
        check("midrst_idle_rready_s1", rready_s[1], 1);
        check("midrst_idle_rid_m0", rid_m[0], 4'h7);
        next();
        clr();

        // Randomized bursts with back-pressure, gaps, bad tags and rare resets.
        left = '{0, 0, 0};
        for (int cyc = 0; cyc < 4000; cyc++) begin
            next();
            rst = ($urandom_range(0, 499) == 0);
            rready_m[0] = ($urandom_range(0, 99) < 70);
            rready_m[1] = ($urandom_range(0, 99) < 70);
            for (int s = 0; s < 3; s++) begin
                if (rst) begin
                    rvalid[s] = 1'b0;
                    left[s]   = 0;
                end else begin
                    if (hs[s] && rvalid[s]) begin
                        rvalid[s] = 1'b0;
                        left[s]--;
                    end
                    if (!rvalid[s]) begin
                        if (left[s] == 0 && $urandom_range(0, 2) == 0) begin
                            pick    = $urandom_range(0, 9);
                            left[s] = $urandom_range(1, 4);
                            rid[s]  = {(pick < 5) ? TAG0 : (pick < 9) ? TAG1 : 4'hF, 4'($urandom)};
                        end
                        if (left[s] > 0 && $urandom_range(0, 3) != 0) begin
                            rvalid[s] = 1'b1;
                            rdata[s]  = $urandom;
                            rresp[s]  = 2'($urandom);
                            rlast[s]  = (left[s] == 1);
                        end
                    end
                end
            end
        end
        next();
        rst = 1'b0;
        clr();
        settle();
        chk_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
